// File: rtl/seg_scan_decoder.sv
// Recovers capacity/location frames from a multiplexed 7-segment display scan.
// Optional macro SEG_CONFIRM_EN: commit a frame only after two identical accepted frames.
module seg_scan_decoder #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [4:0] selector,
    input  logic [7:0] segments_L,
    output logic [2:0] capacity,
    output logic [1:0] location,
    output logic       full_flag,
    output logic       frame_valid,
    output logic       decode_err,
    output logic       link_up
);

    localparam logic [4:0] SEL_S0 = 5'b01000;
    localparam logic [4:0] SEL_S1 = 5'b00100;
    localparam logic [4:0] SEL_S2 = 5'b00010;
    localparam logic [4:0] SEL_S3 = 5'b00001;

    localparam logic [3:0] CODE_U   = 4'd5;
    localparam logic [3:0] CODE_L   = 4'd6;
    localparam logic [3:0] CODE_F   = 4'd7;
    localparam logic [3:0] CODE_BAD = 4'd15;

    localparam logic [7:0]    SETTLE_N  = 8'(SETTLE_CYCLES);
    localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] IDLE_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] IDLE_ONE  = TW'(1);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_CHECK   = 2'd2
    } state_t;

    function automatic logic [3:0] glyph_code(input logic [7:0] g);
        case (g)
            8'h3F:   glyph_code = 4'd0;
            8'h06:   glyph_code = 4'd1;
            8'h5B:   glyph_code = 4'd2;
            8'h4F:   glyph_code = 4'd3;
            8'h66:   glyph_code = 4'd4;
            8'h3E:   glyph_code = CODE_U;
            8'h38:   glyph_code = CODE_L;
            8'h71:   glyph_code = CODE_F;
            default: glyph_code = CODE_BAD;
        endcase
    endfunction

    function automatic logic [4:0] sel_next(input logic [4:0] s);
        case (s)
            SEL_S0:  sel_next = SEL_S1;
            SEL_S1:  sel_next = SEL_S2;
            SEL_S2:  sel_next = SEL_S3;
            SEL_S3:  sel_next = SEL_S0;
            default: sel_next = 5'b00000;
        endcase
    endfunction

    // The glyph sampled at a selector belongs to the slot of the previous digit.
    function automatic logic [4:0] slot_sel(input logic [1:0] idx);
        case (idx)
            2'd0:    slot_sel = SEL_S1;
            2'd1:    slot_sel = SEL_S2;
            2'd2:    slot_sel = SEL_S3;
            2'd3:    slot_sel = SEL_S0;
            default: slot_sel = SEL_S1;
        endcase
    endfunction

    logic [4:0]      r_sel;
    logic [4:0]      r_sel_prev;
    logic [7:0]      r_seg;
    logic [4:0]      r_prev_legal;
    logic            r_prev_valid;
    logic            r_sel_ok;
    logic [7:0]      r_settle;
    logic            r_sampled;
    logic [TW-1:0]   r_idle;
    state_t          r_state;
    logic [1:0]      r_idx;
    logic [3:0][3:0] r_slots;

    logic            w_change;
    logic            w_legal;
    logic            w_in_seq;
    logic            w_sel_bad;
    logic            w_sample;
    logic            w_timeout;
    logic            w_force_hunt;
    logic [3:0]      w_code;
    logic            w_check;
    logic            w_normal;
    logic            w_full;
    logic            w_accept;
    logic            w_reject;
    logic            w_commit;
    state_t          w_state_nxt;
    logic            w_store_en;
    logic [1:0]      w_store_idx;

    assign w_change     = (r_sel != r_sel_prev);
    assign w_legal      = (r_sel == SEL_S0) || (r_sel == SEL_S1) ||
                          (r_sel == SEL_S2) || (r_sel == SEL_S3);
    assign w_in_seq     = !r_prev_valid || (r_sel == sel_next(r_prev_legal));
    assign w_sel_bad    = w_change && !(w_legal && w_in_seq);
    assign w_sample     = !w_change && r_sel_ok && !r_sampled && (r_settle == SETTLE_N);
    assign w_timeout    = !w_change && (r_idle == IDLE_LAST);
    assign w_force_hunt = w_sel_bad || w_timeout;
    assign w_code       = glyph_code(r_seg);

    assign w_check  = (r_state == ST_CHECK);
    assign w_normal = (r_slots[0] <= 4'd4) && (r_slots[1] == 4'd0) &&
                      (r_slots[2] <= 4'd3) && (r_slots[3] == 4'd0);
    assign w_full   = (r_slots[0] == CODE_U) && (r_slots[1] == CODE_L) &&
                      (r_slots[2] == CODE_L) && (r_slots[3] == CODE_F);
    assign w_accept = w_check && (w_normal || w_full);
    assign w_reject = w_check && !(w_normal || w_full);

    // Input capture, change history and selector sequence tracking.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sel        <= 5'b00000;
            r_sel_prev   <= 5'b00000;
            r_seg        <= 8'h00;
            r_prev_legal <= 5'b00000;
            r_prev_valid <= 1'b0;
            r_sel_ok     <= 1'b0;
        end else begin
            r_sel      <= selector;
            r_seg      <= segments_L;
            r_sel_prev <= r_sel;
            if (w_change) begin
                r_prev_legal <= w_legal ? r_sel : 5'b00000;
                r_prev_valid <= w_legal;
                r_sel_ok     <= w_legal && w_in_seq;
            end else if (w_timeout) begin
                r_prev_valid <= 1'b0;
            end
        end
    end

    // Settle counter, idle watchdog and link status.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_settle  <= 8'd0;
            r_sampled <= 1'b1;
            r_idle    <= {TW{1'b0}};
            link_up   <= 1'b0;
        end else if (w_change) begin
            r_settle  <= 8'd1;
            r_sampled <= 1'b0;
            r_idle    <= {TW{1'b0}};
            link_up   <= 1'b1;
        end else begin
            if (w_sample) begin
                r_sampled <= 1'b1;
            end else if (!r_sampled && (r_settle != SETTLE_N)) begin
                r_settle <= r_settle + 8'd1;
            end
            if (r_idle != IDLE_MAX) begin
                r_idle <= r_idle + IDLE_ONE;
            end
            if (w_timeout) begin
                link_up <= 1'b0;
            end
        end
    end

    // Frame FSM state and slot buffer storage.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_HUNT;
            r_idx   <= 2'd0;
            r_slots <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            if (w_store_en) begin
                r_slots[w_store_idx] <= w_code;
                r_idx                <= w_store_idx + 2'd1;
            end
        end
    end

    // Frame FSM next state; CHECK behaves like HUNT so a coincident slot 0 sample is kept.
    always_comb begin
        w_state_nxt = r_state;
        w_store_en  = 1'b0;
        w_store_idx = 2'd0;
        if (w_force_hunt) begin
            w_state_nxt = ST_HUNT;
        end else begin
            case (r_state)
                ST_HUNT, ST_CHECK: begin
                    if (w_sample && (r_sel == SEL_S1)) begin
                        w_store_en  = 1'b1;
                        w_store_idx = 2'd0;
                        w_state_nxt = ST_COLLECT;
                    end else begin
                        w_state_nxt = ST_HUNT;
                    end
                end
                ST_COLLECT: begin
                    if (w_sample) begin
                        if (r_sel == slot_sel(r_idx)) begin
                            w_store_en  = 1'b1;
                            w_store_idx = r_idx;
                            if (r_idx == 2'd3) begin
                                w_state_nxt = ST_CHECK;
                            end else begin
                                w_state_nxt = ST_COLLECT;
                            end
                        end else begin
                            w_state_nxt = ST_HUNT;
                        end
                    end else begin
                        w_state_nxt = ST_COLLECT;
                    end
                end
                default: begin
                    w_state_nxt = ST_HUNT;
                end
            endcase
        end
    end

`ifdef SEG_CONFIRM_EN
    logic [3:0][3:0] r_prime;
    logic            r_prime_valid;

    assign w_commit = w_accept && r_prime_valid && (r_prime == r_slots);

    // Remembers the last accepted frame; a timeout forgets it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_prime       <= 16'h0000;
            r_prime_valid <= 1'b0;
        end else if (w_timeout) begin
            r_prime_valid <= 1'b0;
        end else if (w_accept) begin
            r_prime       <= r_slots;
            r_prime_valid <= 1'b1;
        end
    end
`else
    assign w_commit = w_accept;
`endif

    // Committed outputs and status pulses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            capacity    <= 3'd0;
            location    <= 2'd0;
            full_flag   <= 1'b0;
            frame_valid <= 1'b0;
            decode_err  <= 1'b0;
        end else begin
            frame_valid <= w_commit;
            decode_err  <= w_sel_bad || w_reject;
            if (w_commit) begin
                if (w_full) begin
                    full_flag <= 1'b1;
                end else begin
                    capacity  <= r_slots[0][2:0];
                    location  <= r_slots[2][1:0];
                    full_flag <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: frames, rejects, selector faults, timeout, mid-frame reset.
module tb_seg_scan_decoder;

    localparam int TO_CYC = 200;

    localparam logic [4:0] SEL0 = 5'b01000;
    localparam logic [4:0] SEL1 = 5'b00100;
    localparam logic [4:0] SEL2 = 5'b00010;
    localparam logic [4:0] SEL3 = 5'b00001;

    localparam logic [7:0] G0   = 8'h3F;
    localparam logic [7:0] G1   = 8'h06;
    localparam logic [7:0] G2   = 8'h5B;
    localparam logic [7:0] G3   = 8'h4F;
    localparam logic [7:0] G4   = 8'h66;
    localparam logic [7:0] GU   = 8'h3E;
    localparam logic [7:0] GL   = 8'h38;
    localparam logic [7:0] GF   = 8'h71;
    localparam logic [7:0] GBAD = 8'h77;

    logic       CLK = 1'b0;
    logic       RST;
    logic [4:0] selector;
    logic [7:0] segments_L;
    logic [2:0] capacity;
    logic [1:0] location;
    logic       full_flag;
    logic       frame_valid;
    logic       decode_err;
    logic       link_up;

    int n_checks = 0;
    int n_errors = 0;
    int n_fv     = 0;
    int n_err    = 0;
    int fv_base  = 0;
    int err_base = 0;

    always #5 CLK = ~CLK;

    seg_scan_decoder #(
        .SETTLE_CYCLES (4),
        .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .selector   (selector),
        .segments_L (segments_L),
        .capacity   (capacity),
        .location   (location),
        .full_flag  (full_flag),
        .frame_valid(frame_valid),
        .decode_err (decode_err),
        .link_up    (link_up)
    );

    always @(negedge CLK) begin
        if (frame_valid) n_fv <= n_fv + 1;
        if (decode_err)  n_err <= n_err + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [31:0] cap, input logic [31:0] loc,
                              input logic [31:0] full, input logic [31:0] lnk,
                              input logic [31:0] dfv, input logic [31:0] derr);
        check_eq({tag, " capacity"}, 32'(capacity), cap);
        check_eq({tag, " location"}, 32'(location), loc);
        check_eq({tag, " full_flag"}, 32'(full_flag), full);
        check_eq({tag, " link_up"}, 32'(link_up), lnk);
        check_eq({tag, " frame_valid pulses"}, 32'(n_fv - fv_base), dfv);
        check_eq({tag, " decode_err pulses"}, 32'(n_err - err_base), derr);
        fv_base  = n_fv;
        err_base = n_err;
    endtask

    task automatic step(input logic [4:0] sel, input logic [7:0] seg);
        selector   = sel;
        segments_L = seg;
        repeat (16) @(negedge CLK);
    endtask

    task automatic frame(input logic [7:0] g0, input logic [7:0] g1,
                         input logic [7:0] g2, input logic [7:0] g3);
        step(SEL1, g0);
        step(SEL2, g1);
        step(SEL3, g2);
        step(SEL0, g3);
    endtask

    initial begin
        RST        = 1'b1;
        selector   = SEL0;
        segments_L = G0;
        repeat (3) @(negedge CLK);
        check_eq("reset frame_valid", 32'(frame_valid), 0);
        check_eq("reset decode_err", 32'(decode_err), 0);
        expect_out("reset", 0, 0, 0, 0, 0, 0);
        RST = 1'b0;

        step(SEL0, G0);
        expect_out("idle", 0, 0, 0, 1, 0, 0);

        frame(G3, G0, G2, G0);
        expect_out("frame_3_2", 3, 2, 0, 1, 1, 0);
        frame(G4, G0, G3, G0);
        expect_out("frame_max", 4, 3, 0, 1, 1, 0);
        frame(GU, GL, GL, GF);
        frame(GU, GL, GL, GF);
        expect_out("full", 4, 3, 1, 1, 2, 0);
        frame(G2, G0, G1, G0);
        expect_out("frame_2_1", 2, 1, 0, 1, 1, 0);

        frame(G1, G0, GBAD, G0);
        expect_out("bad_glyph", 2, 1, 0, 1, 0, 1);
        frame(G4, G0, G4, G0);
        expect_out("loc_range", 2, 1, 0, 1, 0, 1);
        frame(G0, G0, G0, G0);
        expect_out("frame_min", 0, 0, 0, 1, 1, 0);
        frame(G1, G0, G3, G0);
        expect_out("frame_1_3", 1, 3, 0, 1, 1, 0);

        step(SEL2, G0);
        step(SEL3, G0);
        step(SEL0, G0);
        expect_out("sel_skip", 1, 3, 0, 1, 0, 1);
        step(5'b00011, G0);
        step(SEL0, G0);
        expect_out("sel_multi", 1, 3, 0, 1, 0, 1);
        frame(G2, G0, G2, G0);
        expect_out("after_sel_err", 2, 2, 0, 1, 1, 0);

        repeat (150) @(negedge CLK);
        expect_out("freeze_early", 2, 2, 0, 1, 0, 0);
        repeat (100) @(negedge CLK);
        expect_out("freeze_timeout", 2, 2, 0, 0, 0, 0);
        frame(G3, G0, G1, G0);
        expect_out("resume", 3, 1, 0, 1, 1, 0);

        step(SEL1, G1);
        step(SEL2, G0);
        RST = 1'b1;
        @(negedge CLK);
        check_eq("rst_mid frame_valid", 32'(frame_valid), 0);
        check_eq("rst_mid decode_err", 32'(decode_err), 0);
        expect_out("rst_mid", 0, 0, 0, 0, 0, 0);
        RST = 1'b0;
        step(SEL3, G3);
        step(SEL0, G0);
        expect_out("partial", 0, 0, 0, 1, 0, 0);
        frame(G1, G0, G2, G0);
        expect_out("after_rst", 1, 2, 0, 1, 1, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
